data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter_pkg.sv | 15 +
 rtl/data_memory_arbiter_rr_arbiter2.sv | 16 +
 rtl/data_memory_arbiter.sv | 132 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   - DEFAULT_DATA_W / DEFAULT_MEM_BITS : default word width and memory index width
//   - state_t                           : arbiter FSM state encoding
package data_memory_arbiter_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_MEM_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin pick (purely combinational).
// Ports:
//   req[1:0]   : request from port 0 / port 1
//   pointer    : preferred port when both request
//   grant[1:0] : one-hot grant (all zero when nobody requests)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  // A lone requester always wins; on contention the pointer decides.
  assign grant[0] = req[0] & (~req[1] | ~pointer);
  assign grant[1] = req[1] & (~req[0] |  pointer);

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Each transaction takes IDLE -> ACCESS -> RESP (three cycles).
// Ports:
//   clock, rst                  : clock, synchronous active-low reset
//   req/we/addr/wdata 0 and 1   : requester inputs (port 0 CPU, port 1 DMA/debug)
//   done/rdata/err 0 and 1      : per-port completion pulse, read data, range error
//   mem_re/mem_we               : memory read/write enables
//   mem_addr/mem_wdata          : memory address and write data
//   mem_rdata                   : memory read data (memory registers it on negedge)
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MEM_BITS = DEFAULT_MEM_BITS
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_reg, state_next;
  logic              ptr_reg;
  logic              port_reg;
  logic              we_reg;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata0_reg;
  logic [DATA_W-1:0] rdata1_reg;

  logic [1:0] req_vec;
  logic [1:0] grant;
  logic       any_req;
  logic       addr_oor;
  logic [1:0] done_vec;

  assign req_vec = {req1, req0};
  assign any_req = |req_vec;

  rr_arbiter2 u_rr (
    .req     (req_vec),
    .pointer (ptr_reg),
    .grant   (grant)
  );

  // Any address bit at or above MEM_BITS means the word lies outside the memory.
  assign addr_oor = |(addr_reg >> MEM_BITS);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, pointer and latched request
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 1'b0;
      port_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && any_req) begin
        // grant is one-hot here, so grant[1] is the winning port number
        port_reg  <= grant[1];
        we_reg    <= grant[1] ? we1    : we0;
        addr_reg  <= grant[1] ? addr1  : addr0;
        wdata_reg <= grant[1] ? wdata1 : wdata0;
      end
      if (state_reg == ST_RESP) begin
        ptr_reg <= ~port_reg;
      end
    end
  end

  // Read data capture: the memory updates mem_rdata on the negedge inside
  // ACCESS, so it is stable at the posedge that ends ACCESS and the result
  // is already registered for the whole RESP cycle.
  always_ff @(posedge clock) begin
    if (!rst) begin
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else if (state_reg == ST_ACCESS && !we_reg) begin
      if (port_reg == 1'b0) rdata0_reg <= addr_oor ? '0 : mem_rdata;
      else                  rdata1_reg <= addr_oor ? '0 : mem_rdata;
    end
  end

  // Memory side: enables only during ACCESS and only for in-range words.
  assign mem_re    = (state_reg == ST_ACCESS) && !we_reg && !addr_oor;
  assign mem_we    = (state_reg == ST_ACCESS) &&  we_reg && !addr_oor;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  // Per-port completion pulses
  for (genvar gi = 0; gi < 2; gi++) begin : g_done
    assign done_vec[gi] = (state_reg == ST_RESP) && (port_reg == 1'(gi));
  end

  assign done0  = done_vec[0];
  assign done1  = done_vec[1];
  assign err0   = done_vec[0] & addr_oor;
  assign err1   = done_vec[1] & addr_oor;
  assign rdata0 = rdata0_reg;
  assign rdata1 = rdata1_reg;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

  localparam int DW    = 32;
  localparam int MB    = 10;
  localparam int DEPTH = 1 << MB;

  logic          clock;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [DW-1:0] addr0, addr1, wdata0, wdata1;
  logic          done0, done1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_done0 = 0;
  int cnt_done1 = 0;

  // Environment memory (driven by the DUT) and the bench's own expectation of it
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW-1:0] ref_mem   [DEPTH];
  logic [DW-1:0] exp_rdata [2];

  data_memory_arbiter #(.DATA_W(DW), .MEM_BITS(MB)) dut (
    .clock     (clock),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done0     (done0),
    .done1     (done1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .err0      (err0),
    .err1      (err1),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory registers reads and writes on the falling edge
  initial mem_rdata = '0;
  always @(negedge clock) begin
    if (mem_we) mem_model[mem_addr[MB-1:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr[MB-1:0]];
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Global invariants, sampled on every falling edge
  always @(negedge clock) begin
    if (done0) cnt_done0++;
    if (done1) cnt_done1++;
    check("excl_mem_en", 32'(mem_re & mem_we), 32'd0);
    check("excl_done",   32'(done0 & done1),   32'd0);
  end

  // One transaction on port p; request held from the IDLE cycle until done
  // (or dropped right after being sampled when drop_early is set).
  task automatic txn(input int p, input bit we, input logic [DW-1:0] addr,
                     input logic [DW-1:0] wd, input bit drop_early);
    bit in_range;
    int c, re_cnt, we_cnt, d0_before, d1_before;
    logic dn;
    in_range  = (addr < DEPTH);
    re_cnt    = 0;
    we_cnt    = 0;
    d0_before = cnt_done0;
    d1_before = cnt_done1;
    dn        = 1'b0;
    @(posedge clock); #1;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    else        begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    for (c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      dn = (p == 0) ? done0 : done1;
      if (dn) break;
      if (drop_early && c == 1) begin
        @(posedge clock); #1;
        if (p == 0) req0 = 0; else req1 = 0;
      end
    end
    check("latency", 32'(c), 32'd3);
    check("err", 32'((p == 0) ? err0 : err1), 32'(!in_range));
    check("mem_re_cycles", 32'(re_cnt), 32'(!we && in_range));
    check("mem_we_cycles", 32'(we_cnt), 32'(we && in_range));
    if (!we) exp_rdata[p] = in_range ? ref_mem[addr[MB-1:0]] : '0;
    if (we && in_range) ref_mem[addr[MB-1:0]] = wd;
    check("rdata0", rdata0, exp_rdata[0]);
    check("rdata1", rdata1, exp_rdata[1]);
    @(posedge clock); #1;
    req0 = 0; req1 = 0;
    check("done0_count", 32'(cnt_done0 - d0_before), 32'(p == 0));
    check("done1_count", 32'(cnt_done1 - d1_before), 32'(p == 1));
    $display("txn port=%0d we=%0d addr=%h wdata=%h drop=%0d rdata0=%h rdata1=%h",
             p, we, addr, wd, drop_early, rdata0, rdata1);
  endtask

  initial begin
    logic [DW-1:0] old_v, new_v, a;
    int d0_before, d1_before, n_dn;
    int dn_idx [4];
    int dn_port [4];

    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = $urandom;
      ref_mem[i]   = mem_model[i];
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    rst = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_err",   32'(err0 | err1), 32'd0);
    check("rst_mem_en", 32'(mem_re | mem_we), 32'd0);
    check("rst_rdata0", rdata0, '0);
    check("rst_rdata1", rdata1, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    @(posedge clock); #1 rst = 1;

    // Single read
    mem_model[5] = 32'h1234;
    ref_mem[5]   = 32'h1234;
    txn(0, 1'b0, 32'd5, 32'h0, 1'b0);
    check("single_read", rdata0, 32'h1234);

    // Write then read on port 1
    txn(1, 1'b1, 32'd7, 32'hDEAD, 1'b0);
    txn(1, 1'b0, 32'd7, 32'h0, 1'b0);
    check("write_read", rdata1, 32'hDEAD);

    // Out of range read
    txn(0, 1'b0, 32'h400, 32'h0, 1'b0);
    check("oor_rdata0", rdata0, '0);

    // Request dropped after being latched still completes
    txn(1, 1'b1, 32'd9, 32'h5555_AAAA, 1'b1);
    txn(0, 1'b0, 32'd9, 32'h0, 1'b1);
    check("drop_read", rdata0, 32'h5555_AAAA);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(MB, DW - 1));
      txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    // Reset during ACCESS of a write to address 3
    old_v = ref_mem[3];
    new_v = 32'hCAFE_F00D;
    d0_before = cnt_done0;
    d1_before = cnt_done1;
    @(posedge clock); #1;
    req0 = 1; we0 = 1; addr0 = 32'd3; wdata0 = new_v;
    @(posedge clock); #1;
    rst = 0;
    @(posedge clock); #1;
    req0 = 0;
    @(negedge clock);
    check("midrst_mem_en", 32'(mem_re | mem_we), 32'd0);
    check("midrst_done", 32'(done0 | done1), 32'd0);
    check("midrst_rdata0", rdata0, '0);
    check("midrst_rdata1", rdata1, '0);
    check("midrst_mem_addr", mem_addr, '0);
    check("midrst_mem_wdata", mem_wdata, '0);
    @(posedge clock); #1 rst = 1;
    repeat (4) @(negedge clock);
    check("midrst_no_done", 32'((cnt_done0 - d0_before) + (cnt_done1 - d1_before)), 32'd0);
    check("midrst_mem3", 32'(mem_model[3] === old_v || mem_model[3] === new_v), 32'd1);
    ref_mem[3]   = mem_model[3];
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    $display("mid-op reset: mem[3]=%h", mem_model[3]);
    txn(0, 1'b0, 32'd3, 32'h0, 1'b0);

    // Contention from reset: both ports request continuously
    @(posedge clock); #1;
    rst = 0;
    req0 = 1; we0 = 0; addr0 = 32'd10;
    req1 = 1; we1 = 0; addr1 = 32'd20;
    repeat (2) @(posedge clock);
    #1 rst = 1;
    n_dn = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if ((done0 || done1) && n_dn < 4) begin
        dn_idx[n_dn]  = n;
        dn_port[n_dn] = done1 ? 1 : 0;
        check("cont_rdata", done1 ? rdata1 : rdata0, done1 ? ref_mem[20] : ref_mem[10]);
        $display("contention done #%0d cycle=%0d port=%0d", n_dn, n, dn_port[n_dn]);
        n_dn++;
      end
    end
    @(posedge clock); #1;
    req0 = 0; req1 = 0;
    check("cont_count", 32'(n_dn), 32'd4);
    if (n_dn == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("cont_port",  32'(dn_port[k]), 32'(k % 2));
        check("cont_cycle", 32'(dn_idx[k]), 32'(3 * (k + 1)));
      end
    end
    exp_rdata[0] = ref_mem[10];
    exp_rdata[1] = ref_mem[20];
    txn(1, 1'b0, 32'd11, 32'h0, 1'b0);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
